// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: stage indices
// and default parameter values.
package pipe_ctrl_pkg;

    localparam int STG_F = 0;
    localparam int STG_D = 1;
    localparam int STG_X = 2;
    localparam int STG_M = 3;
    localparam int STG_W = 4;

    localparam int DEF_STAGES   = 5;
    localparam int DEF_BR_STAGE = STG_X;
    localparam int DEF_CNT_W    = 32;
    localparam int DEF_TIMEOUT  = 1024;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (inc && (q_reg != {W{1'b1}})) begin
            q_reg <= q_reg + 1'b1;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: per-stage hold and bubble/redirect clears,
// latched fetch redirect, dmem-stall watchdog and saturating perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES   = DEF_STAGES,
    parameter int BR_STAGE = DEF_BR_STAGE,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STAGES-1:0] hz_stall,
    input  logic              imem_stall,
    input  logic              dmem_stall,
    input  logic              redirect_valid,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] flush,
    output logic              redirect_pending,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  cnt_cycles,
    output logic [CNT_W-1:0]  cnt_stall,
    output logic [CNT_W-1:0]  cnt_flush
);

    logic              dmem_eff;
    logic [STAGES-1:0] hz_or;
    logic              redir_acc;
    logic              pending_reg;
    logic              pending_next;

    // An unknown dmem_stall must not freeze the pipe.
    assign dmem_eff = (dmem_stall === 1'b1);

    // hz_or[i] is the OR of hz_stall over stage i and every older stage.
    assign hz_or[STAGES-1] = hz_stall[STAGES-1];
    for (genvar gi = 0; gi < STAGES - 1; gi++) begin : g_hz_or
        assign hz_or[gi] = hz_stall[gi] | hz_or[gi+1];
    end

    assign stall[0] = dmem_eff | hz_or[0] | imem_stall;
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_stall
        assign stall[gi] = dmem_eff | hz_or[gi];
    end

    assign redir_acc = redirect_valid & ~stall[BR_STAGE];

    // Fetch clear covers both a fresh redirect and one owed from a stalled fetch.
    assign flush[0] = ~stall[0] & (redir_acc | pending_reg);

    for (genvar gi = 1; gi < STAGES; gi++) begin : g_flush
        if (gi < BR_STAGE) begin : g_wrong_path
            assign flush[gi] = ~stall[gi] & (stall[gi-1] | redir_acc);
        end else begin : g_bubble
            assign flush[gi] = ~stall[gi] & stall[gi-1];
        end
    end

    assign pending_next = stall[0] & (pending_reg | redir_acc);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_reg <= 1'b0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign redirect_pending = pending_reg;

    sat_counter #(.W(CNT_W)) u_cnt_cycles (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .q     (cnt_cycles)
    );

    sat_counter #(.W(CNT_W)) u_cnt_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall[0]),
        .q     (cnt_stall)
    );

    sat_counter #(.W(CNT_W)) u_cnt_flush (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redir_acc),
        .q     (cnt_flush)
    );

    if (TIMEOUT > 0) begin : g_watchdog
        localparam int WD_W = $clog2(TIMEOUT + 1);
        localparam logic [WD_W-1:0] WD_LIMIT    = WD_W'(TIMEOUT);
        localparam logic [WD_W-1:0] WD_LIMIT_M1 = WD_W'(TIMEOUT - 1);

        logic            wd_clr_n;
        logic            wd_inc;
        logic [WD_W-1:0] wd_q;
        logic            err_reg;

        // A cycle without dmem_stall restarts the consecutive count.
        assign wd_clr_n = rst_n & dmem_eff;
        assign wd_inc   = dmem_eff & (wd_q != WD_LIMIT);

        sat_counter #(.W(WD_W)) u_wd (
            .clk   (clk),
            .rst_n (wd_clr_n),
            .inc   (wd_inc),
            .q     (wd_q)
        );

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                err_reg <= 1'b0;
            end else if (wd_inc && (wd_q == WD_LIMIT_M1)) begin
                err_reg <= 1'b1;
            end
        end

        assign timeout_err = err_reg;
    end else begin : g_no_watchdog
        assign timeout_err = 1'b0;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (5 stages, 4-bit counters, TIMEOUT=8).
module tb_pipe_ctrl;

    localparam int STAGES   = 5;
    localparam int BR_STAGE = 2;
    localparam int CNT_W    = 4;
    localparam int TIMEOUT  = 8;

    logic              clk;
    logic              rst_n;
    logic [STAGES-1:0] hz_stall;
    logic              imem_stall;
    logic              dmem_stall;
    logic              redirect_valid;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] flush;
    logic              redirect_pending;
    logic              timeout_err;
    logic [CNT_W-1:0]  cnt_cycles;
    logic [CNT_W-1:0]  cnt_stall;
    logic [CNT_W-1:0]  cnt_flush;

    int checks;
    int errors;

    pipe_ctrl #(
        .STAGES   (STAGES),
        .BR_STAGE (BR_STAGE),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .hz_stall         (hz_stall),
        .imem_stall       (imem_stall),
        .dmem_stall       (dmem_stall),
        .redirect_valid   (redirect_valid),
        .stall            (stall),
        .flush            (flush),
        .redirect_pending (redirect_pending),
        .timeout_err      (timeout_err),
        .cnt_cycles       (cnt_cycles),
        .cnt_stall        (cnt_stall),
        .cnt_flush        (cnt_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        hz_stall       = '0;
        imem_stall     = 1'b0;
        dmem_stall     = 1'b0;
        redirect_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        hz_stall       = '0;
        imem_stall     = 1'b0;
        dmem_stall     = 1'b0;
        redirect_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({redirect_pending, timeout_err} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags pending/err=%b required 00", {redirect_pending, timeout_err});
        end
        checks++;
        if ({cnt_cycles, cnt_stall, cnt_flush} !== 12'h000) begin
            errors++;
            $display("FAIL reset_cnt cyc=%0d stl=%0d fls=%0d required 0 0 0", cnt_cycles, cnt_stall, cnt_flush);
        end
        checks++;
        if ({stall, flush} !== 10'b0) begin
            errors++;
            $display("FAIL reset_comb stall=%b flush=%b required 00000 00000", stall, flush);
        end
        $display("test_reset done");
    endtask

    task automatic test_hazard();
        do_reset();
        hz_stall = 5'b00100;
        settle();
        checks++;
        if (stall !== 5'b00111 || flush !== 5'b01000) begin
            errors++;
            $display("FAIL hz_x stall=%b flush=%b required 00111 01000", stall, flush);
        end
        tick();
        tick();
        tick();
        checks++;
        if (cnt_stall !== 4'd3 || cnt_flush !== 4'd0 || cnt_cycles !== 4'd3) begin
            errors++;
            $display("FAIL hz_cnt stl=%0d fls=%0d cyc=%0d required 3 0 3", cnt_stall, cnt_flush, cnt_cycles);
        end
        hz_stall = 5'b10000;
        settle();
        checks++;
        if (stall !== 5'b11111 || flush !== 5'b00000) begin
            errors++;
            $display("FAIL hz_w stall=%b flush=%b required 11111 00000", stall, flush);
        end
        hz_stall = 5'b01010;
        settle();
        checks++;
        if (stall !== 5'b01111 || flush !== 5'b10000) begin
            errors++;
            $display("FAIL hz_md stall=%b flush=%b required 01111 10000", stall, flush);
        end
        hz_stall   = 5'b00000;
        imem_stall = 1'b1;
        settle();
        checks++;
        if (stall !== 5'b00001 || flush !== 5'b00010) begin
            errors++;
            $display("FAIL hz_imem stall=%b flush=%b required 00001 00010", stall, flush);
        end
        imem_stall = 1'b0;
        dmem_stall = 1'bx;
        settle();
        checks++;
        if (stall !== 5'b00000 || flush !== 5'b00000) begin
            errors++;
            $display("FAIL dmem_x stall=%b flush=%b required 00000 00000", stall, flush);
        end
        dmem_stall = 1'b0;
        $display("test_hazard done");
    endtask

    task automatic test_redirect();
        do_reset();
        redirect_valid = 1'b1;
        settle();
        checks++;
        if (flush !== 5'b00011 || redirect_pending !== 1'b0) begin
            errors++;
            $display("FAIL redir_flush flush=%b pend=%b required 00011 0", flush, redirect_pending);
        end
        tick();
        redirect_valid = 1'b0;
        settle();
        checks++;
        if (cnt_flush !== 4'd1 || redirect_pending !== 1'b0 || flush !== 5'b00000) begin
            errors++;
            $display("FAIL redir_after fls=%0d pend=%b flush=%b required 1 0 00000", cnt_flush, redirect_pending, flush);
        end
        $display("test_redirect done");
    endtask

    task automatic test_pending();
        do_reset();
        imem_stall     = 1'b1;
        redirect_valid = 1'b1;
        settle();
        checks++;
        if (flush !== 5'b00010 || stall !== 5'b00001) begin
            errors++;
            $display("FAIL pend_c1 flush=%b stall=%b required 00010 00001", flush, stall);
        end
        tick();
        redirect_valid = 1'b0;
        settle();
        checks++;
        if (redirect_pending !== 1'b1 || flush[0] !== 1'b0) begin
            errors++;
            $display("FAIL pend_c2 pend=%b flush0=%b required 1 0", redirect_pending, flush[0]);
        end
        tick();
        tick();
        checks++;
        if (redirect_pending !== 1'b1) begin
            errors++;
            $display("FAIL pend_c4 pend=%b required 1", redirect_pending);
        end
        tick();
        imem_stall = 1'b0;
        settle();
        checks++;
        if (flush !== 5'b00001 || redirect_pending !== 1'b1) begin
            errors++;
            $display("FAIL pend_c5 flush=%b pend=%b required 00001 1", flush, redirect_pending);
        end
        tick();
        checks++;
        if (redirect_pending !== 1'b0 || flush !== 5'b00000 || cnt_flush !== 4'd1) begin
            errors++;
            $display("FAIL pend_c6 pend=%b flush=%b fls=%0d required 0 00000 1", redirect_pending, flush, cnt_flush);
        end
        $display("test_pending done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        imem_stall     = 1'b1;
        redirect_valid = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b0;
        settle();
        checks++;
        if (redirect_pending !== 1'b1 || cnt_flush !== 4'd2) begin
            errors++;
            $display("FAIL b2b_pend pend=%b fls=%0d required 1 2", redirect_pending, cnt_flush);
        end
        imem_stall = 1'b0;
        settle();
        checks++;
        if (flush !== 5'b00001) begin
            errors++;
            $display("FAIL b2b_rel flush=%b required 00001", flush);
        end
        tick();
        checks++;
        if (flush !== 5'b00000 || redirect_pending !== 1'b0) begin
            errors++;
            $display("FAIL b2b_once flush=%b pend=%b required 00000 0", flush, redirect_pending);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_dmem_redirect();
        do_reset();
        dmem_stall     = 1'b1;
        redirect_valid = 1'b1;
        settle();
        checks++;
        if (stall !== 5'b11111 || flush !== 5'b00000) begin
            errors++;
            $display("FAIL dmem_hold stall=%b flush=%b required 11111 00000", stall, flush);
        end
        tick();
        checks++;
        if (cnt_flush !== 4'd0 || redirect_pending !== 1'b0) begin
            errors++;
            $display("FAIL dmem_ign fls=%0d pend=%b required 0 0", cnt_flush, redirect_pending);
        end
        dmem_stall = 1'b0;
        settle();
        checks++;
        if (flush !== 5'b00011) begin
            errors++;
            $display("FAIL dmem_rel flush=%b required 00011", flush);
        end
        tick();
        redirect_valid = 1'b0;
        settle();
        checks++;
        if (cnt_flush !== 4'd1) begin
            errors++;
            $display("FAIL dmem_cnt fls=%0d required 1", cnt_flush);
        end
        $display("test_dmem_redirect done");
    endtask

    task automatic test_watchdog();
        do_reset();
        dmem_stall = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL wd_7 err=%b required 0", timeout_err);
        end
        dmem_stall = 1'b0;
        tick();
        dmem_stall = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL wd_restart err=%b required 0", timeout_err);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL wd_8 err=%b required 1", timeout_err);
        end
        dmem_stall = 1'b0;
        tick();
        tick();
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL wd_sticky err=%b required 1", timeout_err);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL wd_clr err=%b required 0", timeout_err);
        end
        rst_n = 1'b1;
        $display("test_watchdog done");
    endtask

    task automatic test_saturate();
        do_reset();
        imem_stall = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (cnt_stall !== 4'd15 || cnt_cycles !== 4'd15) begin
            errors++;
            $display("FAIL sat stl=%0d cyc=%0d required 15 15", cnt_stall, cnt_cycles);
        end
        imem_stall = 1'b0;
        $display("test_saturate done");
    endtask

    task automatic test_reset_pending();
        do_reset();
        imem_stall     = 1'b1;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
        rst_n          = 1'b0;
        tick();
        checks++;
        if (redirect_pending !== 1'b0) begin
            errors++;
            $display("FAIL rst_pend pend=%b required 0", redirect_pending);
        end
        rst_n      = 1'b1;
        imem_stall = 1'b0;
        settle();
        checks++;
        if (flush !== 5'b00000) begin
            errors++;
            $display("FAIL rst_noflush flush=%b required 00000", flush);
        end
        $display("test_reset_pending done");
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        hz_stall       = '0;
        imem_stall     = 1'b0;
        dmem_stall     = 1'b0;
        redirect_valid = 1'b0;
        test_reset();
        test_hazard();
        test_redirect();
        test_pending();
        test_back_to_back();
        test_dmem_redirect();
        test_watchdog();
        test_saturate();
        test_reset_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised pipeline stall/flush controller, successor to the fixed 5-stage combinational stall logic. Generalises to STAGES stages with a per-stage hazard vector, automatic bubble insertion and a configurable branch-resolve stage. Adds sequential behaviour: a latched redirect that waits for a stalled fetch, a memory-stall watchdog and saturating performance counters. Sits beside the datapath and drives every pipeline register's enable/clear.

Parameters:
STAGES, 5, number of pipeline stages; index 0 = fetch, STAGES-1 = writeback.
BR_STAGE, 2, stage that resolves branches/redirects (1..STAGES-2).
CNT_W, 32, width of each performance counter.
TIMEOUT, 1024, consecutive dmem-stall cycles before timeout_err; 0 disables the watchdog.

Ports:
clk  in  1  clock.
rst_n  in  1  synchronous active-low reset.
hz_stall  in  STAGES  per-stage hazard hold request; bit j holds stage j and all younger stages.
imem_stall  in  1  instruction memory not ready.
dmem_stall  in  1  data memory not ready; freezes the whole pipe. X is treated as 0.
redirect_valid  in  1  taken branch/jump resolved in BR_STAGE.
stall  out  STAGES  per-stage hold (register enable = ~stall[i]).
flush  out  STAGES  per-stage clear (register loads bubble).
redirect_pending  out  1  redirect accepted, fetch flush still owed.
timeout_err  out  1  sticky watchdog error.
cnt_cycles  out  CNT_W  cycles since reset.
cnt_stall  out  CNT_W  cycles with stall[0]=1.
cnt_flush  out  CNT_W  accepted redirects.

Behaviour:
- Reset (rst_n=0 at clk edge): redirect_pending=0, timeout_err=0, all counters=0, watchdog count=0. stall and flush are combinational and follow the rules below during reset.
- stall[i] = dmem_stall | OR over j>=i of hz_stall[j] | (i==0 & imem_stall). The output is therefore monotonic: stall[i+1] implies stall[i].
- Bubble insertion: flush[i+1]=1 when stall[i]=1 and stall[i+1]=0. Stage i+1 advances and stage i holds.
- flush[i] is never asserted while stall[i]=1; stall wins in every case.
- Redirect acceptance: redirect_valid counts only when stall[BR_STAGE]=0. The source must hold it otherwise. An accepted redirect asserts flush[i] for every i<BR_STAGE with stall[i]=0, in the same cycle (zero latency).
- If stage 0 is stalled at acceptance, redirect_pending sets on the next edge. While it is pending, flush[0] asserts in the first cycle that stall[0]=0, and redirect_pending clears at the end of that cycle. This discards the wrong-path fetch.
- A new accepted redirect while one is pending keeps it pending; there is no double count in flush[0]. cnt_flush still increments.
- Watchdog: counts consecutive cycles with dmem_stall=1 and clears on dmem_stall=0. When the count reaches TIMEOUT, timeout_err=1 and stays 1 until reset. The count saturates at TIMEOUT.
- Counters increment at the end of each qualifying cycle and saturate at all-ones; they do not wrap.
- Reset mid-operation: a pending redirect is dropped and the owed flush[0] is not issued.

Decomposition:
- Package pipe_ctrl_pkg holds the stage index constants (STG_F=0, STG_D=1, STG_X=2, STG_M=3, STG_W=4) and the default parameter values.
- One sub-module, sat_counter (parameter W; inputs clk, rst_n, inc; output q), instantiated three times for the performance counters and reused for the watchdog with W=$clog2(TIMEOUT+1).

Test Plan:
- hz_stall=5'b00100, all else 0 -> stall=5'b00111, flush=5'b01000; after 3 cycles cnt_stall=3, cnt_flush=0.
- redirect_valid=1 for 1 cycle, no stalls -> flush=5'b00011 in that cycle, redirect_pending stays 0, cnt_flush=1.
- imem_stall=1 for 4 cycles, redirect_valid pulsed in cycle 1 -> flush=5'b00010 in cycle 1, redirect_pending=1 in cycles 2-4, flush[0]=1 in cycle 5 (imem released), redirect_pending=0 in cycle 6.
- dmem_stall=1 together with redirect_valid=1 -> stall=5'b11111, flush=0, redirect ignored, cnt_flush unchanged. Redirect takes effect on the first cycle after dmem_stall drops.
- TIMEOUT=8, dmem_stall=1 for 7 cycles, low 1 cycle, then high 8 cycles -> timeout_err stays 0 until the 8th consecutive cycle, then stays 1. rst_n=0 for one edge clears it.
- CNT_W=4, imem_stall=1 for 20 cycles -> cnt_stall holds at 15.
